ifetch_buffer: RTL and testbench

IFETCH_BUFFER -- requirements
Module: ifetch_buffer

---
 rtl/ifetch_buffer_pkg.sv | 25 ++
 rtl/sync_fifo.sv | 57 +++++
 rtl/ifetch_buffer.sv | 100 ++++++++++
 tb/tb_ifetch_buffer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/ifetch_buffer_pkg.sv
// Shared types and constants for the instruction fetch buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package ifetch_buffer_pkg;

  // Canonical RISC-V NOP (addi x0, x0, 0), presented to decode when nothing is valid.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Sequential fetch stride: one 32-bit instruction word.
  localparam logic [31:0] PC_INC = 32'd4;

  // One queued fetch: the instruction word tagged with the address it came from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

  // Fetch addresses are always word aligned; low two bits of a target are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & ~32'h3;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO: registered write, combinational head read, clear input.
// Latency: a word written at the end of cycle N is visible at rd_dat in cycle N+1.
// Backpressure: writes accepted when not full, or when full with a same-cycle read.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             rd_rdy,
  output logic [WIDTH-1:0] rd_dat,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  // Storage is deliberately left unreset; only pointers and occupancy are reset.
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign do_rd  = rd_rdy && !empty;
  assign do_wr  = wr_vld && (!full || do_rd);
  assign rd_dat = mem[rd_ptr];

  // Pointer and occupancy update; reset and clear both empty the queue and win over traffic.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Data array write; a write made during clear lands in a slot that is already dead.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_dat;
  end

endmodule

// File: rtl/ifetch_buffer.sv
// Instruction prefetch buffer between a 1-cycle instruction memory and decode.
// Latency: request in C0, word queued at end of C1, offered to decode in C2; redirect costs 3 cycles.
// Backpressure: id_ready stalls the head; fetch stops once queued + in-flight words reach DEPTH.
module ifetch_buffer
  import ifetch_buffer_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   fetch_pc;
  logic [31:0]   tag_pc;
  logic          inflight;
  logic          squash;
  logic          push_vld;
  logic          pop_rdy;
  logic          q_full;
  logic          q_empty;
  logic [CW-1:0] q_count;
  logic [CW-1:0] credit_used;
  fetch_entry_t  push_entry;
  fetch_entry_t  head_entry;

  // Every in-flight word owns a reserved slot, so a returning word can never find the queue full.
  // The explicit full term is implied by the credit check and only guards against misuse.
  assign credit_used = q_count + CW'(inflight);
  assign imem_req    = !rst && !redirect_valid && !q_full && (credit_used < CW'(DEPTH));
  assign imem_addr   = fetch_pc;

  // Next fetch address: reset vector, redirect target, or sequential step on each request.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc <= align_pc(redirect_pc);
    end else if (imem_req) begin
      fetch_pc <= fetch_pc + PC_INC;
    end
  end

  // Track the single outstanding memory read and remember a redirect for the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= 1'b0;
      squash   <= 1'b0;
    end else begin
      inflight <= imem_req;
      squash   <= redirect_valid;
    end
  end

  // Address tag travelling alongside the outstanding read.
  always_ff @(posedge clk) begin
    if (imem_req) tag_pc <= fetch_pc;
  end

  // A word returning in a redirect cycle (or right after one) belongs to the dead path.
  assign push_vld         = inflight && !squash && !redirect_valid;
  assign push_entry.pc    = tag_pc;
  assign push_entry.instr = imem_rdata;

  // Decode handshake; redirect discards the head instead of consuming it.
  assign pop_rdy = id_valid && id_ready && !redirect_valid;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_queue (
    .clk    (clk),
    .rst    (rst),
    .clr    (redirect_valid),
    .wr_vld (push_vld),
    .wr_dat (push_entry),
    .rd_rdy (pop_rdy),
    .rd_dat (head_entry),
    .full   (q_full),
    .empty  (q_empty),
    .count  (q_count)
  );

  // Decode sees a clean NOP at PC 0 whenever there is nothing valid, including during reset.
  assign id_valid = !rst && !q_empty;
  assign id_instr = id_valid ? head_entry.instr : NOP_INSTR;
  assign id_pc    = id_valid ? head_entry.pc    : 32'h0000_0000;

endmodule

// File: tb/tb_ifetch_buffer.sv
// Self-checking bench for ifetch_buffer against a request-list reference model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_ifetch_buffer;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;

  always #5 clk = ~clk;

  ifetch_buffer #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Every live fetch request, oldest first: what has been asked for and not yet consumed or discarded.
  typedef struct {
    logic [31:0] addr;
    int          cyc;
  } req_t;

  req_t        pend[$];
  logic [31:0] exp_fetch;
  logic        prev_req;
  logic [31:0] prev_addr;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at cycle %0d", tag, act, exp, cyc);
  endtask

  // Memory contents: a bijection of the address, so every PC carries a distinct word (0x0 -> 0x93).
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h0000_0093;
  endfunction

  // One clock cycle: drive inputs, compare outputs with the model, advance the model.
  task automatic run_cycle(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
    logic e_req;
    logic e_vld;
    req_t e;
    rst            = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    id_ready       = rdy;
    imem_rdata     = prev_req ? mem_word(prev_addr) : $urandom();
    #2;
    // A word requested in cycle t is offered to decode from cycle t+2.
    e_vld = 1'b0;
    if (!r && pend.size() > 0) e_vld = (pend[0].cyc <= cyc - 2);
    // Fetch only while fewer than DEPTH words are owed to decode.
    e_req = !r && !rv && (pend.size() < DEPTH);
    check_eq("imem_req", {31'b0, imem_req}, {31'b0, e_req});
    if (e_req) check_eq("imem_addr", imem_addr, exp_fetch);
    check_eq("id_valid", {31'b0, id_valid}, {31'b0, e_vld});
    if (e_vld) begin
      check_eq("id_pc", id_pc, pend[0].addr);
      check_eq("id_instr", id_instr, mem_word(pend[0].addr));
    end else begin
      check_eq("id_pc_idle", id_pc, 32'h0);
      check_eq("id_instr_idle", id_instr, NOP);
    end
    prev_req  = imem_req;
    prev_addr = imem_addr;
    if (r) begin
      pend.delete();
      exp_fetch = RESET_PC;
    end else if (rv) begin
      pend.delete();
      exp_fetch = rpc & ~32'h3;
    end else begin
      if (e_vld && rdy) void'(pend.pop_front());
      if (e_req) begin
        e.addr = exp_fetch;
        e.cyc  = cyc;
        pend.push_back(e);
        exp_fetch = exp_fetch + 32'd4;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    logic        r;
    logic        rv;
    logic        rdy;
    logic [31:0] rpc;
    int          ready_pct;
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    id_ready       = 1'b0;
    imem_rdata     = 32'h0;
    exp_fetch      = RESET_PC;
    prev_req       = 1'b0;
    prev_addr      = 32'h0;
    @(posedge clk);
    #1;

    // Reset, then free-running decode: first instruction two cycles after release.
    repeat (2) run_cycle(1'b1, 1'b0, 32'h0, 1'b1);
    repeat (8) run_cycle(1'b0, 1'b0, 32'h0, 1'b1);

    // Decode stalled for 10 cycles: fetch stops at DEPTH, head held, then drains in order.
    repeat (2) run_cycle(1'b1, 1'b0, 32'h0, 1'b0);
    repeat (10) run_cycle(1'b0, 1'b0, 32'h0, 1'b0);
    repeat (10) run_cycle(1'b0, 1'b0, 32'h0, 1'b1);

    // Redirect to an unaligned target with 3 entries queued and a word in flight.
    repeat (2) run_cycle(1'b1, 1'b0, 32'h0, 1'b0);
    repeat (4) run_cycle(1'b0, 1'b0, 32'h0, 1'b0);
    run_cycle(1'b0, 1'b1, 32'h0000_0102, 1'b0);
    repeat (6) run_cycle(1'b0, 1'b0, 32'h0, 1'b1);

    // Back-to-back redirects: the last target wins.
    run_cycle(1'b0, 1'b1, 32'h0000_0200, 1'b1);
    run_cycle(1'b0, 1'b1, 32'h0000_0303, 1'b1);
    repeat (6) run_cycle(1'b0, 1'b0, 32'h0, 1'b1);

    // Address wrap from the top of memory back to 0.
    run_cycle(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
    repeat (8) run_cycle(1'b0, 1'b0, 32'h0, 1'b1);

    // Fill the queue, then pop while the last word returns in the same cycle.
    repeat (6) run_cycle(1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 12; i++) run_cycle(1'b0, 1'b0, 32'h0, i[0]);

    // Reset together with a redirect: reset wins.
    repeat (5) run_cycle(1'b0, 1'b0, 32'h0, 1'b1);
    run_cycle(1'b1, 1'b1, 32'h0000_0040, 1'b1);
    repeat (6) run_cycle(1'b0, 1'b0, 32'h0, 1'b1);

    // Random traffic with varying decode pressure, redirects and occasional resets.
    ready_pct = 100;
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) begin
        case ($urandom_range(0, 3))
          0:       ready_pct = 10;
          1:       ready_pct = 50;
          2:       ready_pct = 90;
          default: ready_pct = 100;
        endcase
      end
      r   = ($urandom_range(0, 199) == 0);
      rv  = ($urandom_range(0, 24) == 0);
      rpc = $urandom();
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
      rdy = ($urandom_range(0, 99) < ready_pct);
      run_cycle(r, rv, rpc, rdy);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
